// File: rtl/dec_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : dec_queue_if
//  Description : Handshake bundle for the decode queue. It carries the
//                fetch-side write port (in_valid/in_ready/inst_in), the
//                issue-side read port (out_valid/out_ready/inst_t/illegal)
//                and the occupancy count.
//                slave  : the decode queue itself
//                master : the fetch/issue environment driving it
//  Revision    : 1.0  initial release
// ============================================================================
interface dec_queue_if #(
    parameter int CNT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst_in;
    logic             out_valid;
    logic             out_ready;
    logic [44:0]      inst_t;
    logic             illegal;
    logic [CNT_W-1:0] count;

    modport slave (
        input  in_valid, inst_in, out_ready,
        output in_ready, out_valid, inst_t, illegal, count
    );

    modport master (
        output in_valid, inst_in, out_ready,
        input  in_ready, out_valid, inst_t, illegal, count
    );
endinterface
`default_nettype wire

// File: rtl/dec_queue.sv
`default_nettype none
// ============================================================================
//  Module      : dec_queue
//  Description : Registered decode stage between fetch and issue. RV32
//                R-type ALU ops (and I-type ALU ops when ITYPE_EN=1) are
//                decoded into the 45-bit micro-op
//                {rs1[4:0], rs2[4:0], rd[4:0], imm[19:0], opcode[9:0]} with
//                opcode = {type[4:0], op[4:0]}, then buffered in a DEPTH-entry
//                FIFO. Unsupported encodings enqueue an all-zero micro-op
//                with the illegal flag set.
//  Ports       : clk, rst (sync, active-high), flush (sync clear)
//                q_if.slave : in_valid/in_ready/inst_in (write side),
//                             out_valid/out_ready/inst_t/illegal (read side),
//                             count (occupancy 0..DEPTH)
//  Revision    : 1.0  initial release
// ============================================================================
module dec_queue #(
    parameter int DEPTH    = 4,
    parameter int ITYPE_EN = 1,
    parameter int CNT_W    = 3
) (
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     flush,
    dec_queue_if.slave    q_if
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]  inst_opc;
    logic [2:0]  inst_f3;
    logic [6:0]  inst_f7;
    logic [4:0]  dec_type;
    logic [4:0]  dec_op;
    logic [4:0]  dec_rs2;
    logic [19:0] dec_imm;
    logic        dec_illegal;
    logic [44:0] dec_uop;

    assign inst_opc = q_if.inst_in[6:0];
    assign inst_f3  = q_if.inst_in[14:12];
    assign inst_f7  = q_if.inst_in[31:25];

    always_comb begin
        dec_type = 5'd0;
        dec_op   = 5'd0;
        dec_rs2  = q_if.inst_in[24:20];
        dec_imm  = 20'd0;
        case (inst_opc)
            7'b0110011: begin
                dec_type = 5'd5;
                case ({inst_f7, inst_f3})
                    10'h000: dec_op = 5'd1;   // add
                    10'h100: dec_op = 5'd2;   // sub
                    10'h001: dec_op = 5'd3;   // sll
                    10'h002: dec_op = 5'd4;   // slt
                    10'h003: dec_op = 5'd5;   // sltu
                    10'h004: dec_op = 5'd6;   // xor
                    10'h005: dec_op = 5'd7;   // srl
                    10'h105: dec_op = 5'd8;   // sra
                    10'h006: dec_op = 5'd9;   // or
                    10'h007: dec_op = 5'd10;  // and
                    default: dec_op = 5'd0;
                endcase
            end
            7'b0010011: begin
                if (ITYPE_EN != 0) begin
                    dec_type = 5'd4;
                    dec_rs2  = 5'd0;
                    dec_imm  = {{8{q_if.inst_in[31]}}, q_if.inst_in[31:20]};
                    case (inst_f3)
                        3'd0: dec_op = 5'd1;
                        3'd2: dec_op = 5'd4;
                        3'd3: dec_op = 5'd5;
                        3'd4: dec_op = 5'd6;
                        3'd6: dec_op = 5'd9;
                        3'd7: dec_op = 5'd10;
                        // Shifts carry a 5-bit shamt; the upper immediate bits
                        // are really funct7 and select logical vs arithmetic.
                        3'd1: begin
                            dec_imm = {15'd0, q_if.inst_in[24:20]};
                            dec_op  = (inst_f7 == 7'h00) ? 5'd3 : 5'd0;
                        end
                        default: begin
                            dec_imm = {15'd0, q_if.inst_in[24:20]};
                            if (inst_f7 == 7'h00) begin
                                dec_op = 5'd7;
                            end else if (inst_f7 == 7'h20) begin
                                dec_op = 5'd8;
                            end else begin
                                dec_op = 5'd0;
                            end
                        end
                    endcase
                end
            end
            default: dec_op = 5'd0;
        endcase
        // op==0 is never a valid code, so it doubles as the illegal marker.
        dec_illegal = (dec_op == 5'd0);
        dec_uop     = dec_illegal ? 45'd0
                    : {q_if.inst_in[19:15], dec_rs2, q_if.inst_in[11:7],
                       dec_imm, dec_type, dec_op};
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [45:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;
    logic [45:0]      head;

    // in_ready depends only on occupancy, never on out_ready.
    assign q_if.in_ready  = (count_q != FULL_CNT);
    assign q_if.out_valid = (count_q != '0);
    assign push           = q_if.in_valid & q_if.in_ready;
    assign pop            = q_if.out_valid & q_if.out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; entries are only observable through the
    // pointers, which are.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            mem_q[wr_ptr_q] <= {dec_illegal, dec_uop};
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign q_if.inst_t  = q_if.out_valid ? head[44:0] : 45'd0;
    assign q_if.illegal = q_if.out_valid ? head[45]   : 1'b0;
    assign q_if.count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_dec_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dec_queue
//  Description : Self-checking bench for dec_queue. A queue-based model with
//                a table-style decoder predicts every visible output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dec_queue;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    logic flush;
    int   n_cmp;
    int   n_fail;

    dec_queue_if #(.CNT_W(3)) bus  ();
    dec_queue_if #(.CNT_W(3)) bus0 ();

    dec_queue #(.DEPTH(DEPTH), .ITYPE_EN(1), .CNT_W(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .q_if  (bus.slave)
    );

    dec_queue #(.DEPTH(DEPTH), .ITYPE_EN(0), .CNT_W(3)) dut0 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .q_if  (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: queue of {illegal, micro-op}
    logic [45:0] mq [$];

    function automatic logic [45:0] ref_decode(input logic [31:0] w, input bit iten);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          op;
        logic [19:0] imm;
        opc = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        op  = 0;
        imm = 20'd0;
        if (opc == 7'h33) begin
            if (f7 == 7'h00) begin
                case (f3)
                    3'd0: op = 1;  3'd1: op = 3;  3'd2: op = 4;  3'd3: op = 5;
                    3'd4: op = 6;  3'd5: op = 7;  3'd6: op = 9;  default: op = 10;
                endcase
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                op = 2;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                op = 8;
            end
            if (op != 0) return {1'b0, w[19:15], w[24:20], w[11:7], 20'd0, 5'd5, 5'(op)};
        end else if (opc == 7'h13 && iten) begin
            imm = 20'(signed'(w[31:20]));
            case (f3)
                3'd0: op = 1;  3'd2: op = 4;  3'd3: op = 5;
                3'd4: op = 6;  3'd6: op = 9;  3'd7: op = 10;
                3'd1: begin
                    imm = {15'd0, w[24:20]};
                    op  = (f7 == 7'h00) ? 3 : 0;
                end
                default: begin
                    imm = {15'd0, w[24:20]};
                    op  = (f7 == 7'h00) ? 7 : (f7 == 7'h20) ? 8 : 0;
                end
            endcase
            if (op != 0) return {1'b0, w[19:15], 5'd0, w[11:7], imm, 5'd4, 5'(op)};
        end
        return {1'b1, 45'd0};
    endfunction

    // Expected {out_valid, in_ready, count, illegal, inst_t}
    function automatic logic [50:0] exp_vec();
        logic [45:0] h;
        h = (mq.size() != 0) ? mq[0] : 46'd0;
        return {mq.size() != 0, mq.size() != DEPTH, 3'(mq.size()), h};
    endfunction

    function automatic logic [50:0] act_vec();
        return {bus.out_valid, bus.in_ready, bus.count, bus.illegal, bus.inst_t};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] f7;
        int k;
        k = $urandom_range(0, 3);
        case ($urandom_range(0, 2))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        case (k)
            0:       return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'h33};
            1:       return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'h13};
            2:       return {12'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'h13};
            default: return $urandom;
        endcase
    endfunction

    // One clock: drive at negedge, advance the model over the posedge.
    task automatic cycle(input bit v, input logic [31:0] w, input bit r,
                         input bit f, input bit rs);
        bit push;
        bit pop;
        bus.in_valid  = v;
        bus.inst_in   = w;
        bus.out_ready = r;
        flush         = f;
        rst           = rs;
        push = v && (mq.size() < DEPTH);
        pop  = r && (mq.size() != 0);
        @(posedge clk);
        if (rs || f) begin
            mq.delete();
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(ref_decode(w, 1'b1));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        rst          = 1'b0;
    endtask

    task automatic test_reset();
        cycle(0, 32'h0, 0, 0, 1);
        cycle(0, 32'h0, 0, 0, 1);
        n_cmp++;
        if (act_vec() !== {1'b0, 1'b1, 3'd0, 1'b0, 45'd0}) begin
            n_fail++;
            $display("FAIL reset_state act=%h exp=%h", act_vec(), {1'b0, 1'b1, 3'd0, 1'b0, 45'd0});
        end
    endtask

    task automatic test_rtype();
        cycle(1, 32'h002081B3, 0, 0, 0);
        n_cmp++;
        if ({bus.out_valid, bus.illegal, bus.inst_t} !==
            {1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 20'd0, 10'h0A1}) begin
            n_fail++;
            $display("FAIL add_decode act=%h exp=%h", {bus.out_valid, bus.illegal, bus.inst_t},
                     {1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 20'd0, 10'h0A1});
        end
        cycle(0, 32'h0, 1, 0, 0);
        // every R-type op plus some bad funct7 values, via the model
        for (int i = 0; i < 16; i++) begin
            logic [31:0] w;
            w = {(i[3] ? 7'h20 : 7'h00), 5'd7, 5'd9, i[2:0], 5'd11, 7'h33};
            if (i == 15) w[31:25] = 7'h01;
            cycle(1, w, 0, 0, 0);
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rtype_%0d act=%h exp=%h", i, act_vec(), exp_vec());
            end
            cycle(0, 32'h0, 1, 0, 0);
        end
    endtask

    task automatic test_itype();
        bus0.in_valid  = 1'b1;
        bus0.inst_in   = 32'hFFF00293;
        bus0.out_ready = 1'b0;
        cycle(1, 32'hFFF00293, 0, 0, 0);
        bus0.in_valid  = 1'b0;
        n_cmp++;
        if ({bus.out_valid, bus.illegal, bus.inst_t} !==
            {1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 20'hFFFFF, 10'h081}) begin
            n_fail++;
            $display("FAIL addi_decode act=%h exp=%h", {bus.out_valid, bus.illegal, bus.inst_t},
                     {1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 20'hFFFFF, 10'h081});
        end
        n_cmp++;
        if ({bus0.out_valid, bus0.illegal, bus0.inst_t} !== {1'b1, 1'b1, 45'd0}) begin
            n_fail++;
            $display("FAIL addi_itype_off act=%h exp=%h", {bus0.out_valid, bus0.illegal, bus0.inst_t},
                     {1'b1, 1'b1, 45'd0});
        end
        bus0.out_ready = 1'b1;
        cycle(0, 32'h0, 1, 0, 0);
        n_cmp++;
        if ({bus0.out_valid, bus0.count} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL itype_off_drain act=%h exp=%h", {bus0.out_valid, bus0.count}, 4'd0);
        end
    endtask

    task automatic test_shift();
        cycle(1, 32'h4030D093, 0, 0, 0);
        n_cmp++;
        if ({bus.illegal, bus.inst_t} !== {1'b0, 5'd1, 5'd0, 5'd1, 20'h00003, 10'h088}) begin
            n_fail++;
            $display("FAIL srai_decode act=%h exp=%h", {bus.illegal, bus.inst_t},
                     {1'b0, 5'd1, 5'd0, 5'd1, 20'h00003, 10'h088});
        end
        cycle(1, 32'h0230D093, 1, 0, 0);
        n_cmp++;
        if ({bus.illegal, bus.inst_t} !== {1'b1, 45'd0}) begin
            n_fail++;
            $display("FAIL srli_bad_f7 act=%h exp=%h", {bus.illegal, bus.inst_t}, {1'b1, 45'd0});
        end
        cycle(1, 32'h0030D093, 1, 0, 0);
        n_cmp++;
        if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL srli_ok act=%h exp=%h", act_vec(), exp_vec());
        end
        cycle(1, 32'h40309093, 1, 0, 0);
        n_cmp++;
        if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL slli_bad_f7 act=%h exp=%h", act_vec(), exp_vec());
        end
        cycle(0, 32'h0, 1, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            cycle(1, rand_inst(), 0, 0, 0);
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL fill_%0d act=%h exp=%h", i, act_vec(), exp_vec());
            end
        end
        n_cmp++;
        if ({bus.in_ready, bus.count} !== {1'b0, 3'd4}) begin
            n_fail++;
            $display("FAIL full_hold act=%h exp=%h", {bus.in_ready, bus.count}, {1'b0, 3'd4});
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1, rand_inst(), 1, 0, 0);
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL stream_%0d act=%h exp=%h", i, act_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (bus.count !== 3'd3) begin
            n_fail++;
            $display("FAIL stream_count act=%0d exp=3", bus.count);
        end
    endtask

    task automatic test_flush();
        while (mq.size() > 0) cycle(0, 32'h0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, rand_inst(), 0, 0, 0);
        cycle(1, 32'h002081B3, 1, 1, 0);
        n_cmp++;
        if (act_vec() !== {1'b0, 1'b1, 3'd0, 1'b0, 45'd0}) begin
            n_fail++;
            $display("FAIL flush_clear act=%h exp=%h", act_vec(), {1'b0, 1'b1, 3'd0, 1'b0, 45'd0});
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, rand_inst(), 0, 0, 0);
        cycle(1, rand_inst(), 0, 0, 0);
        cycle(1, 32'h002081B3, 1, 1, 1);
        n_cmp++;
        if (act_vec() !== {1'b0, 1'b1, 3'd0, 1'b0, 45'd0}) begin
            n_fail++;
            $display("FAIL reset_mid act=%h exp=%h", act_vec(), {1'b0, 1'b1, 3'd0, 1'b0, 45'd0});
        end
        cycle(1, 32'h00000000, 0, 0, 0);
        n_cmp++;
        if ({bus.out_valid, bus.illegal, bus.inst_t} !== {1'b1, 1'b1, 45'd0}) begin
            n_fail++;
            $display("FAIL zero_word act=%h exp=%h", {bus.out_valid, bus.illegal, bus.inst_t},
                     {1'b1, 1'b1, 45'd0});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0);
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_%0d act=%h exp=%h", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        n_cmp          = 0;
        n_fail         = 0;
        rst            = 1'b1;
        flush          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.inst_in    = 32'h0;
        bus.out_ready  = 1'b0;
        bus0.in_valid  = 1'b0;
        bus0.inst_in   = 32'h0;
        bus0.out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_rtype();
        test_itype();
        test_shift();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
